// File: rtl/s2mm_sched_pkg.sv
// Shared definitions for the S2MM command scheduler: DataMover command/status
// field positions, FSM state types and the 72-bit command builder.
package s2mm_sched_pkg;

    localparam int CMD_W      = 72;
    localparam int BTT_LSB    = 0;
    localparam int BTT_W      = 23;
    localparam int TYPE_BIT   = 23;
    localparam int EOF_BIT    = 30;
    localparam int SADDR_LSB  = 32;
    localparam int TAG_LSB    = 64;

    localparam int STS_TAG_LSB = 0;
    localparam int STS_INTERR  = 4;
    localparam int STS_DECERR  = 5;
    localparam int STS_SLVERR  = 6;
    localparam int STS_OKAY    = 7;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} ch_state_t;
    typedef enum logic {ARB, ISSUE} issue_state_t;

    // INCR burst with EOF set; DSA, DRR and the reserved nibble stay zero.
    function automatic logic [CMD_W-1:0] build_cmd(input logic [BTT_W-1:0] btt,
                                                   input logic [31:0]      saddr,
                                                   input logic [3:0]       tag);
        logic [CMD_W-1:0] c;
        c                      = '0;
        c[BTT_LSB +: BTT_W]    = btt;
        c[TYPE_BIT]            = 1'b1;
        c[EOF_BIT]             = 1'b1;
        c[SADDR_LSB +: 32]     = saddr;
        c[TAG_LSB +: 4]        = tag;
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just past the previous
// winner, pointer only moves when the grant is consumed.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  mask, hi_req, pick;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i > int'(ptr_q));
        end
        hi_req = req & mask;
        pick   = (hi_req != '0) ? hi_req : req;
        gnt    = pick & (~pick + N'(1));
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) ptr_d = IW'(i);
            end
        end
    end

    // Pointer starts on the last channel so channel 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= IW'(N - 1);
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/s2mm_cmd_scheduler.sv
// Shares one DataMover S2MM cmd/status port between NUM_CH capture channels:
// splits captures into PKT_BYTES commands, round-robins channels, routes status by TAG.
module s2mm_cmd_scheduler
    import s2mm_sched_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int PKT_BYTES = 4096,
    parameter int MAX_OUTST = 8
) (
    input  logic                  axilite_clk,
    input  logic                  axilite_rst,
    input  logic [NUM_CH-1:0]     ch_start,
    input  logic [NUM_CH-1:0]     ch_abort,
    input  logic [NUM_CH*32-1:0]  ch_base,
    input  logic [NUM_CH*32-1:0]  ch_size,
    output logic [NUM_CH-1:0]     ch_busy,
    output logic [NUM_CH-1:0]     ch_done,
    output logic [NUM_CH-1:0]     ch_err,
    output logic [71:0]           m_axis_cmd_tdata,
    output logic                  m_axis_cmd_tvalid,
    input  logic                  m_axis_cmd_tready,
    input  logic [7:0]            s_axis_sts_tdata,
    input  logic                  s_axis_sts_tvalid,
    output logic                  s_axis_sts_tready,
    output logic                  sts_orphan
);
    localparam logic [31:0] PKT32 = 32'(PKT_BYTES);

    issue_state_t        iss_q, iss_d;
    logic [3:0]          gch_q, gch_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [3:0]          total_q, total_d;
    logic                orphan_q, orphan_d;

    logic [NUM_CH-1:0]    req, gnt, sts_hit;
    logic [NUM_CH*32-1:0] addr_flat, rem_flat;
    logic                 hs, advance, sts_bad;
    logic [3:0]           sts_tag, gnt_idx;
    logic [31:0]          sel_addr, sel_rem;
    logic [BTT_W-1:0]     sel_btt;
    logic [31:0]          hs_btt;

    assign hs      = (iss_q == ISSUE) && m_axis_cmd_tready;
    assign hs_btt  = {9'b0, cmd_q[BTT_LSB +: BTT_W]};
    assign sts_tag = s_axis_sts_tdata[STS_TAG_LSB +: 4];
    assign sts_bad = !s_axis_sts_tdata[STS_OKAY] | s_axis_sts_tdata[STS_SLVERR]
                   | s_axis_sts_tdata[STS_DECERR] | s_axis_sts_tdata[STS_INTERR];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        ch_state_t   st_q, st_d;
        logic [31:0] addr_q, addr_d, rem_q, rem_d;
        logic [3:0]  outst_q, outst_d;
        logic        err_q, err_d, done_q, done_d, abt_q, abt_d;
        logic        inc, dec, pend;

        assign pend = (iss_q == ISSUE) && (gch_q == 4'(gi));
        assign inc  = hs && (gch_q == 4'(gi));
        assign dec  = s_axis_sts_tvalid && (sts_tag == 4'(gi)) && (outst_q != 4'd0);

        always_comb begin
            st_d    = st_q;
            addr_d  = addr_q;
            rem_d   = rem_q;
            err_d   = err_q;
            abt_d   = abt_q;
            done_d  = 1'b0;
            outst_d = outst_q + {3'b0, inc} - {3'b0, dec};
            if (dec && sts_bad) err_d = 1'b1;
            if (inc) begin
                addr_d = addr_q + hs_btt;
                rem_d  = (rem_q > hs_btt) ? (rem_q - hs_btt) : 32'd0;
            end
            case (st_q)
                IDLE: begin
                    if (ch_start[gi]) begin
                        err_d  = 1'b0;
                        abt_d  = 1'b0;
                        addr_d = ch_base[gi*32 +: 32];
                        rem_d  = ch_size[gi*32 +: 32];
                        if (ch_size[gi*32 +: 32] == 32'd0) done_d = 1'b1;
                        else                               st_d   = RUN;
                    end
                end
                RUN: begin
                    if (ch_abort[gi]) begin
                        st_d  = DRAIN;
                        rem_d = 32'd0;
                        abt_d = 1'b1;
                    end else if (rem_q == 32'd0) begin
                        st_d = DRAIN;
                    end
                end
                DRAIN: begin
                    // A command still held on the port will bump outst; wait for it.
                    if (outst_q == 4'd0 && !pend) begin
                        st_d   = IDLE;
                        done_d = !abt_q;
                    end
                end
                default: st_d = IDLE;
            endcase
        end

        always_ff @(posedge axilite_clk or posedge axilite_rst) begin
            if (axilite_rst) begin
                st_q    <= IDLE;
                addr_q  <= '0;
                rem_q   <= '0;
                outst_q <= '0;
                err_q   <= 1'b0;
                done_q  <= 1'b0;
                abt_q   <= 1'b0;
            end else begin
                st_q    <= st_d;
                addr_q  <= addr_d;
                rem_q   <= rem_d;
                outst_q <= outst_d;
                err_q   <= err_d;
                done_q  <= done_d;
                abt_q   <= abt_d;
            end
        end

        assign req[gi]                = (st_q == RUN) && (rem_q != 32'd0) && !ch_abort[gi];
        assign sts_hit[gi]            = dec;
        assign addr_flat[gi*32 +: 32] = addr_q;
        assign rem_flat[gi*32 +: 32]  = rem_q;
        assign ch_busy[gi]            = (st_q != IDLE);
        assign ch_done[gi]            = done_q;
        assign ch_err[gi]             = err_q;
    end

    assign advance = (iss_q == ARB) && (total_q < 4'(MAX_OUTST)) && (req != '0);

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk     (axilite_clk),
        .rst     (axilite_rst),
        .req     (req),
        .advance (advance),
        .gnt     (gnt)
    );

    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_rem  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                gnt_idx  = 4'(i);
                sel_addr = sel_addr | addr_flat[i*32 +: 32];
                sel_rem  = sel_rem  | rem_flat[i*32 +: 32];
            end
        end
        sel_btt = (sel_rem > PKT32) ? BTT_W'(PKT_BYTES) : sel_rem[BTT_W-1:0];
    end

    always_comb begin
        iss_d    = iss_q;
        gch_d    = gch_q;
        cmd_d    = cmd_q;
        total_d  = total_q + {3'b0, hs} - {3'b0, (sts_hit != '0)};
        orphan_d = orphan_q | (s_axis_sts_tvalid && (sts_hit == '0));
        case (iss_q)
            ARB: begin
                if (advance) begin
                    iss_d = ISSUE;
                    gch_d = gnt_idx;
                    cmd_d = build_cmd(sel_btt, sel_addr, gnt_idx);
                end
            end
            ISSUE: begin
                if (m_axis_cmd_tready) iss_d = ARB;
            end
            default: iss_d = ARB;
        endcase
    end

    always_ff @(posedge axilite_clk or posedge axilite_rst) begin
        if (axilite_rst) begin
            iss_q    <= ARB;
            gch_q    <= '0;
            cmd_q    <= '0;
            total_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            iss_q    <= iss_d;
            gch_q    <= gch_d;
            cmd_q    <= cmd_d;
            total_q  <= total_d;
            orphan_q <= orphan_d;
        end
    end

    assign m_axis_cmd_tdata  = cmd_q;
    assign m_axis_cmd_tvalid = (iss_q == ISSUE);
    assign s_axis_sts_tready = 1'b1;
    assign sts_orphan        = orphan_q;

endmodule

// File: tb/tb_s2mm_cmd_scheduler.sv
// Directed bench for s2mm_cmd_scheduler (8 channels, 4 KiB packets, 2 outstanding).
module tb_s2mm_cmd_scheduler;
    localparam int NCH = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NCH-1:0]     ch_start = '0, ch_abort = '0;
    logic [NCH*32-1:0]  ch_base = '0, ch_size = '0;
    logic [NCH-1:0]     ch_busy, ch_done, ch_err;
    logic [71:0]        cmd_tdata;
    logic               cmd_tvalid;
    logic               cmd_tready = 1'b1;
    logic [7:0]         sts_tdata = '0;
    logic               sts_tvalid = 1'b0;
    logic               sts_tready, sts_orphan;

    logic [71:0] cmds[$];
    int          done_cnt[NCH];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    s2mm_cmd_scheduler #(.NUM_CH(NCH), .PKT_BYTES(4096), .MAX_OUTST(2)) dut (
        .axilite_clk       (clk),
        .axilite_rst       (rst),
        .ch_start          (ch_start),
        .ch_abort          (ch_abort),
        .ch_base           (ch_base),
        .ch_size           (ch_size),
        .ch_busy           (ch_busy),
        .ch_done           (ch_done),
        .ch_err            (ch_err),
        .m_axis_cmd_tdata  (cmd_tdata),
        .m_axis_cmd_tvalid (cmd_tvalid),
        .m_axis_cmd_tready (cmd_tready),
        .s_axis_sts_tdata  (sts_tdata),
        .s_axis_sts_tvalid (sts_tvalid),
        .s_axis_sts_tready (sts_tready),
        .sts_orphan        (sts_orphan)
    );

    // Sampled mid-cycle: a command seen here is accepted on the next rising edge.
    always @(negedge clk) begin
        if (cmd_tvalid && cmd_tready) cmds.push_back(cmd_tdata);
        for (int i = 0; i < NCH; i++) if (ch_done[i]) done_cnt[i]++;
    end

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected command: DRR=0, EOF=1, DSA=0, TYPE=1 (0x4080_0000 | BTT).
    function automatic logic [71:0] exp_cmd(input logic [3:0] tag, input logic [31:0] addr,
                                            input logic [22:0] btt);
        return {4'h0, tag, addr, 32'h4080_0000 | {9'h0, btt}};
    endfunction

    function automatic logic [71:0] get_cmd(input int i);
        if (cmds.size() > i) return cmds[i];
        return {72{1'b1}};
    endfunction

    task automatic do_reset();
        rst = 1'b1; ch_start = '0; ch_abort = '0; sts_tvalid = 1'b0; sts_tdata = '0;
        cmd_tready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        cmds.delete();
        for (int i = 0; i < NCH; i++) done_cnt[i] = 0;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] base, input logic [31:0] size);
        ch_base[ch*32 +: 32] = base;
        ch_size[ch*32 +: 32] = size;
        ch_start[ch]         = 1'b1;
    endtask

    task automatic pulse_start();
        tick();
        ch_start = '0;
    endtask

    task automatic send_sts(input logic [7:0] v);
        sts_tvalid = 1'b1;
        sts_tdata  = v;
        tick();
        sts_tvalid = 1'b0;
        sts_tdata  = '0;
    endtask

    task automatic wait_cmds(input int n, input string tag);
        int b = 0;
        while (cmds.size() < n && b < 200) begin tick(); b++; end
        check_eq(tag, 72'(cmds.size()), 72'(n));
    endtask

    task automatic wait_done(input int ch, input int n, input string tag);
        int b = 0;
        while (done_cnt[ch] < n && b < 200) begin tick(); b++; end
        tick();
        check_eq(tag, 72'(done_cnt[ch]), 72'(n));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) tick();
        check_eq("in_reset_outputs", 72'({ch_busy, ch_done, ch_err, cmd_tvalid, sts_orphan, sts_tready}),
                 72'(27'h1));
        do_reset();
        check_eq("after_reset_outputs", 72'({ch_busy, ch_done, ch_err, cmd_tvalid, sts_orphan, sts_tready}),
                 72'(27'h1));

        // ch0 10000 bytes -> 4096, 4096, 1808; two-outstanding limit
        set_ch(0, 32'h1000_0000, 32'd10000);
        pulse_start();
        check_eq("lat_n1_tvalid", 72'(cmd_tvalid), 72'(0));
        tick();
        check_eq("lat_n2_tvalid", 72'(cmd_tvalid), 72'(1));
        check_eq("lat_n2_tdata", cmd_tdata, {4'h0, 4'h0, 32'h1000_0000, 32'h4080_1000});
        check_eq("ch0_busy", 72'(ch_busy), 72'(8'h01));
        wait_cmds(2, "limit_two_cmds");
        repeat (8) tick();
        check_eq("limit_cmd_count", 72'(cmds.size()), 72'(2));
        check_eq("limit_tvalid_low", 72'(cmd_tvalid), 72'(0));
        send_sts(8'h80);
        wait_cmds(3, "limit_third_cmd");
        check_eq("ch0_cmd1", get_cmd(1), {4'h0, 4'h0, 32'h1000_1000, 32'h4080_1000});
        check_eq("ch0_cmd2", get_cmd(2), {4'h0, 4'h0, 32'h1000_2000, 32'h4080_0710});
        send_sts(8'h80);
        check_eq("ch0_no_early_done", 72'(done_cnt[0]), 72'(0));
        send_sts(8'h80);
        wait_done(0, 1, "ch0_done_once");
        check_eq("ch0_idle", 72'(ch_busy), 72'(0));
        check_eq("ch0_total_cmds", 72'(cmds.size()), 72'(3));

        // ch0 and ch2 started together -> ch0, ch2, ch0, ch2
        do_reset();
        set_ch(0, 32'h3000_0000, 32'd8192);
        set_ch(2, 32'h4000_0000, 32'd8192);
        pulse_start();
        wait_cmds(2, "rr_first_pair");
        send_sts(8'h80);
        send_sts(8'h82);
        wait_cmds(4, "rr_second_pair");
        check_eq("rr_cmd0", get_cmd(0), exp_cmd(4'd0, 32'h3000_0000, 23'd4096));
        check_eq("rr_cmd1", get_cmd(1), exp_cmd(4'd2, 32'h4000_0000, 23'd4096));
        check_eq("rr_cmd2", get_cmd(2), exp_cmd(4'd0, 32'h3000_1000, 23'd4096));
        check_eq("rr_cmd3", get_cmd(3), exp_cmd(4'd2, 32'h4000_1000, 23'd4096));
        send_sts(8'h80);
        send_sts(8'h82);
        wait_done(0, 1, "rr_ch0_done");
        wait_done(2, 1, "rr_ch2_done");

        // SLVERR on ch1: err sticky, done still pulses, next start clears err
        do_reset();
        set_ch(1, 32'h2000_0000, 32'd8192);
        pulse_start();
        wait_cmds(2, "err_cmds");
        send_sts(8'h41);
        check_eq("err_set", 72'(ch_err), 72'(8'h02));
        send_sts(8'h81);
        wait_done(1, 1, "err_done_pulse");
        check_eq("err_sticky", 72'(ch_err), 72'(8'h02));
        set_ch(1, 32'h2000_0000, 32'd0);
        pulse_start();
        check_eq("size0_done_n1", 72'(ch_done), 72'(8'h02));
        check_eq("size0_err_cleared", 72'(ch_err), 72'(0));
        tick();
        check_eq("size0_done_single", 72'(ch_done), 72'(0));
        repeat (4) tick();
        check_eq("size0_no_cmd", 72'(cmds.size()), 72'(2));
        check_eq("size0_not_busy", 72'(ch_busy), 72'(0));

        // ch3 abort while its first command is held by tready low
        do_reset();
        cmd_tready = 1'b0;
        set_ch(3, 32'h5000_0000, 32'd16384);
        pulse_start();
        tick();
        ch_abort[3] = 1'b1;
        tick();
        ch_abort = '0;
        repeat (3) tick();
        check_eq("abort_cmd_held", 72'(cmd_tvalid), 72'(1));
        check_eq("abort_cmd_data", cmd_tdata, exp_cmd(4'd3, 32'h5000_0000, 23'd4096));
        cmd_tready = 1'b1;
        wait_cmds(1, "abort_cmd_completes");
        repeat (10) tick();
        check_eq("abort_no_more_cmds", 72'(cmds.size()), 72'(1));
        check_eq("abort_still_busy", 72'(ch_busy), 72'(8'h08));
        send_sts(8'h83);
        repeat (4) tick();
        check_eq("abort_busy_drops", 72'(ch_busy), 72'(0));
        check_eq("abort_no_done", 72'(done_cnt[3]), 72'(0));
        check_eq("abort_no_orphan", 72'(sts_orphan), 72'(0));

        // Orphan status for idle ch5, then reset in the middle of a run
        send_sts(8'h85);
        check_eq("orphan_set", 72'(sts_orphan), 72'(1));
        check_eq("orphan_no_err", 72'(ch_err), 72'(0));
        set_ch(0, 32'h1000_0000, 32'd10000);
        pulse_start();
        tick();
        check_eq("midrun_tvalid", 72'(cmd_tvalid), 72'(1));
        rst = 1'b1;
        #2;
        check_eq("midrun_reset_outputs", 72'({ch_busy, ch_done, ch_err, cmd_tvalid, sts_orphan, sts_tready}),
                 72'(27'h1));
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check_eq("post_reset_outputs", 72'({ch_busy, ch_done, ch_err, cmd_tvalid, sts_orphan, sts_tready}),
                 72'(27'h1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
